// File: rtl/serial_add_unit.sv
// rtl/serial_add_unit.sv - bit-serial adder/subtractor driving a single fulladder cell

// Single-bit full adder cell fed one bit pair per cycle.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Pure combinational sum and carry of one bit position.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

module serial_add_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [WIDTH-1:0] sum_sh_q,    sum_sh_d;
    logic             carry_q,     carry_d;
    logic             c_msb_q,     c_msb_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q,  overflow_d;

    logic fa_s;
    logic fa_cout;

    fulladder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Next-state, datapath shifting and handshake decode; handshakes depend on state only.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        carry_d     = carry_q;
        c_msb_d     = c_msb_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtraction becomes A + ~B + 1: invert B and seed the carry with 1.
                    a_sh_d  = op_a;
                    b_sh_d  = op_sub ? ~op_b : op_b;
                    carry_d = op_sub;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = (sum_sh_q >> 1) | {fa_s, {(WIDTH - 1){1'b0}}};
                carry_d  = fa_cout;
                count_d  = count_q + CW'(1);
                // Carry into the MSB is kept so signed overflow can be formed at the last bit.
                if (count_q == CNT_PEN) begin
                    c_msb_d = fa_cout;
                end
                if (count_q == CNT_LAST) begin
                    result_d    = sum_sh_d;
                    carry_out_d = fa_cout;
                    overflow_d  = c_msb_q ^ fa_cout;
                    state_d     = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            count_q     <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            c_msb_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            carry_q     <= carry_d;
            c_msb_q     <= c_msb_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// tb/tb_serial_add_unit.sv - randomized self-checking bench for serial_add_unit

module tb_serial_add_unit;

    localparam int WIDTH = 32;

    logic             clock;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    serial_add_unit #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {overflow, carry, result}.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] r;
        logic        c;
        logic        v;
        longint      sr;
        logic [32:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        r    = sub ? (a - b) : (a + b);
        c    = sub ? (a >= b) : wide[32];
        sr   = sub ? (longint'($signed(a)) - longint'($signed(b)))
                   : (longint'($signed(a)) + longint'($signed(b)));
        v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {v, c, r};
    endfunction

    // After the accept edge: keep in_valid high with junk operands to show they are ignored.
    task automatic scramble_inputs();
        in_valid = 1'b1;
        op_a     = $urandom;
        op_b     = $urandom;
        op_sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clock); #1;
            w++;
        end
        check_eq("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        @(posedge clock); #1;
        scramble_inputs();
    endtask

    task automatic finish_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int          n = 0;
        logic        ready_bad = 1'b0;
        logic [33:0] exp;
        while (!out_valid && n < 40) begin
            @(posedge clock); #1;
            n++;
            if (in_ready) ready_bad = 1'b1;
        end
        in_valid = 1'b0;
        exp = model(a, b, sub);
        check_eq("latency", n, WIDTH);
        check_eq("in_ready_busy", ready_bad, 0);
        check_eq("result", result, exp[31:0]);
        check_eq("carry_out", carry_out, exp[32]);
        check_eq("overflow", overflow, exp[33]);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check_eq("retire_ready_valid", {in_ready, out_valid}, 2'b10);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        start_op(a, b, sub);
        finish_op(a, b, sub);
        retire();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ha, hb, na, nb, held_r;
        logic        hs, ns, held_c, held_v, hold_bad;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_in_ready", in_ready, 1);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_result", result, 0);
        check_eq("reset_carry", carry_out, 0);
        check_eq("reset_overflow", overflow, 0);
        resetn = 1'b1;
        @(posedge clock); #1;

        run_op(32'd5, 32'd3, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(32'd3, 32'd5, 1'b1);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1);

        // Backpressure in DONE with a pending request, then back-to-back accept.
        ha = 32'hCAFE_0001; hb = 32'h1234_5678; hs = 1'b1;
        na = $urandom; nb = $urandom; ns = 1'($urandom_range(0, 1));
        start_op(ha, hb, hs);
        finish_op(ha, hb, hs);
        held_r = result; held_c = carry_out; held_v = overflow;
        hold_bad = 1'b0;
        in_valid = 1'b1; op_a = na; op_b = nb; op_sub = ns;
        repeat (10) begin
            @(posedge clock); #1;
            if (!out_valid || in_ready || result !== held_r ||
                carry_out !== held_c || overflow !== held_v) hold_bad = 1'b1;
        end
        check_eq("hold_stable", hold_bad, 0);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check_eq("hold_back_to_idle", {in_ready, out_valid}, 2'b10);
        @(posedge clock); #1;
        check_eq("hold_new_accepted", in_ready, 0);
        scramble_inputs();
        finish_op(na, nb, ns);
        retire();

        for (int i = 0; i < 24; i++) begin
            run_op(pick(), pick(), 1'($urandom_range(0, 1)));
        end

        // Leave nonzero outputs behind, then reset asynchronously mid-run.
        run_op(32'h8000_0000, 32'h8000_0001, 1'b0);
        start_op(32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b0);
        repeat (10) @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check_eq("midreset_result", result, 0);
        check_eq("midreset_carry", carry_out, 0);
        check_eq("midreset_overflow", overflow, 0);
        check_eq("midreset_ready_valid", {in_ready, out_valid}, 2'b10);
        in_valid = 1'b0;
        #2;
        resetn = 1'b1;
        @(posedge clock); #1;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
